// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// MEM_BYTES bounds the fetch-address check enabled by IFETCH_ADDR_CHECK_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    DONE,
    FAULT
  } fetchStateT;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [31:0] MEM_BYTES = 32'd128;

  // Word offset to byte offset: sign-extend, then scale by 4.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control-unit / instruction-memory bus of the fetch unit.
// master = control unit + memory side, slave = instruction_fetch.
interface instruction_fetch_if;

  logic        fetch_req;
  logic        pc_update;
  logic [1:0]  PCSrc;
  logic [15:0] Immediate;
  logic [31:0] RegTarget;
  logic [31:0] IDataOut;
  logic [31:0] IAddr;
  logic        RW;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        fetch_done;
  logic        fault;

  modport master (
    output fetch_req, pc_update, PCSrc, Immediate, RegTarget, IDataOut,
    input  IAddr, RW, IR, PC, PC4, fetch_done, fault
  );

  modport slave (
    input  fetch_req, pc_update, PCSrc, Immediate, RegTarget, IDataOut,
    output IAddr, RW, IR, PC, PC4, fetch_done, fault
  );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection: sequential, PC-relative branch, pseudo-direct jump,
// or register target. All arithmetic wraps modulo 2^32.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcSrc_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] jumpIndex_i,
  input  logic [31:0] regTarget_i,
  output logic [31:0] nextPc_o
);

  logic [31:0] pcPlus4;

  assign pcPlus4 = pc_i + 32'd4;

  always_comb begin
    nextPc_o = pcPlus4;
    case (pcSrc_i)
      PCSRC_PLUS4:  nextPc_o = pcPlus4;
      PCSRC_BRANCH: nextPc_o = pcPlus4 + branchOffset(imm_i);
      PCSRC_JUMP:   nextPc_o = {pcPlus4[31:28], jumpIndex_i, 2'b00};
      PCSRC_REG:    nextPc_o = regTarget_i;
      default:      nextPc_o = pcPlus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle instruction fetch unit: IDLE -> REQ -> CAPT -> DONE.
// Define IFETCH_ADDR_CHECK_EN to trap misaligned/out-of-range fetches in FAULT.
module instruction_fetch
  import fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  instruction_fetch_if.slave bus
);

  fetchStateT  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] nextPc;
  logic        addrBad;

  pc_next u_pcNext (
    .pc_i        (pc_q),
    .pcSrc_i     (bus.PCSrc),
    .imm_i       (bus.Immediate),
    .jumpIndex_i (ir_q[25:0]),
    .regTarget_i (bus.RegTarget),
    .nextPc_o    (nextPc)
  );

  // PC moves only on a committed update in IDLE; IR loads only when CAPT closes.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (state_q == IDLE && bus.pc_update) pc_d = nextPc;
    if (state_q == CAPT) ir_d = bus.IDataOut;
  end

  // The check looks at pc_d so a simultaneous update is validated, not the stale PC.
`ifdef IFETCH_ADDR_CHECK_EN
  assign addrBad = (pc_d[1:0] != 2'b00) || (pc_d > (MEM_BYTES - 32'd4));
`else
  assign addrBad = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.fetch_req) state_d = addrBad ? FAULT : REQ;
      REQ:     state_d = CAPT;
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.RW         = (state_q == REQ) || (state_q == CAPT);
    bus.fetch_done = (state_q == DONE);
`ifdef IFETCH_ADDR_CHECK_EN
    bus.fault      = (state_q == FAULT);
`else
    bus.fault      = 1'b0;
`endif
  end

  assign bus.IAddr = pc_q;
  assign bus.PC    = pc_q;
  assign bus.PC4   = pc_q + 32'd4;
  assign bus.IR    = ir_q;

endmodule
